// File: rtl/demux_1_2_stream_if.sv
// demux_1_2_stream_if: producer stream plus the two consumer streams of the 1:2 demux
interface demux_1_2_stream_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             sel;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  modport slave (
    input  in_data, in_valid, sel, a_ready, b_ready,
    output in_ready, a_data, a_valid, b_data, b_valid
  );
  modport master (
    output in_data, in_valid, sel, a_ready, b_ready,
    input  in_ready, a_data, a_valid, b_data, b_valid
  );
endinterface

// File: rtl/demux_1_2_stream.sv
// demux_1_2_stream: registered 1:2 stream demux with a FIFO per output; DEMUX_1_2_STREAM_COUNT_EN adds push counters and full_stall
module demux_1_2_stream #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst,
  demux_1_2_stream_if.slave s
`ifdef DEMUX_1_2_STREAM_COUNT_EN
  ,
  output logic [15:0] a_count,
  output logic [15:0] b_count,
  output logic        full_stall
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [AW-1:0]    wr_q [2];
  logic [AW-1:0]    wr_d [2];
  logic [AW-1:0]    rd_q [2];
  logic [AW-1:0]    rd_d [2];
  logic [CW-1:0]    cnt_q [2];
  logic [CW-1:0]    cnt_d [2];
  logic [1:0]       full, empty, push, pop;
  logic             acc;
  // readiness from occupancy only, then per-FIFO push/pop and next pointers
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      full[c]  = cnt_q[c] == CW'(DEPTH);
      empty[c] = cnt_q[c] == '0;
    end
    acc  = s.in_valid && (s.sel ? !full[1] : !full[0]);
    push = {s.sel, !s.sel} & {2{acc}};
    pop  = ~empty & {s.b_ready, s.a_ready};
    for (int c = 0; c < 2; c++) begin
      wr_d[c]  = push[c] ? wr_q[c] + 1'b1 : wr_q[c];
      rd_d[c]  = pop[c] ? rd_q[c] + 1'b1 : rd_q[c];
      cnt_d[c] = cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
    end
  end
  assign s.in_ready = s.sel ? !full[1] : !full[0];
  assign s.a_valid  = !empty[0];
  assign s.b_valid  = !empty[1];
  assign s.a_data   = mem_q[0][rd_q[0]];
  assign s.b_data   = mem_q[1][rd_q[1]];
  // FIFO storage, pointers and occupancy; reset clears everything including storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        wr_q[c]  <= '0;
        rd_q[c]  <= '0;
        cnt_q[c] <= '0;
        for (int i = 0; i < DEPTH; i++) mem_q[c][i] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) mem_q[c][wr_q[c]] <= s.in_data;
        wr_q[c]  <= wr_d[c];
        rd_q[c]  <= rd_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end
`ifdef DEMUX_1_2_STREAM_COUNT_EN
  logic [15:0] a_count_q, b_count_q;
  // accepted-word counters, wrapping naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      a_count_q <= a_count_q + 16'(push[0]);
      b_count_q <= b_count_q + 16'(push[1]);
    end
  end
  assign a_count    = a_count_q;
  assign b_count    = b_count_q;
  assign full_stall = s.in_valid && !s.in_ready;
`endif
endmodule

// File: tb/tb_demux_1_2_stream.sv
// tb_demux_1_2_stream: directed + random stimulus, queue-based reference model and scoreboard monitor
module tb_demux_1_2_stream;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_a[$];
  logic [WIDTH-1:0] exp_b[$];
  logic [15:0] cnt_a_m = '0;
  logic [15:0] cnt_b_m = '0;
  demux_1_2_stream_if #(.WIDTH(WIDTH)) bus ();
`ifdef DEMUX_1_2_STREAM_COUNT_EN
  logic [15:0] a_count, b_count;
  logic        full_stall;
`endif
  demux_1_2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .s(bus.slave)
`ifdef DEMUX_1_2_STREAM_COUNT_EN
    ,
    .a_count(a_count),
    .b_count(b_count),
    .full_stall(full_stall)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // scoreboard: mid-cycle, compare DUT against the queue model, then apply the upcoming edge's transfers
  always @(negedge clk) begin
    if (rst) begin
      exp_a.delete();
      exp_b.delete();
      cnt_a_m = '0;
      cnt_b_m = '0;
    end else begin
      logic acc;
      acc = bus.in_valid && (bus.sel ? exp_b.size() < DEPTH : exp_a.size() < DEPTH);
      check("a_valid", 64'(bus.a_valid), 64'(exp_a.size() != 0));
      check("b_valid", 64'(bus.b_valid), 64'(exp_b.size() != 0));
      if (exp_a.size() != 0) check("a_data", 64'(bus.a_data), 64'(exp_a[0]));
      if (exp_b.size() != 0) check("b_data", 64'(bus.b_data), 64'(exp_b[0]));
      check("in_ready", 64'(bus.in_ready), 64'(bus.sel ? exp_b.size() < DEPTH : exp_a.size() < DEPTH));
`ifdef DEMUX_1_2_STREAM_COUNT_EN
      check("full_stall", 64'(full_stall), 64'(bus.in_valid && !acc));
      check("a_count", 64'(a_count), 64'(cnt_a_m));
      check("b_count", 64'(b_count), 64'(cnt_b_m));
`endif
      if (bus.a_ready && exp_a.size() != 0) void'(exp_a.pop_front());
      if (bus.b_ready && exp_b.size() != 0) void'(exp_b.pop_front());
      if (acc) begin
        if (bus.sel) begin
          exp_b.push_back(bus.in_data);
          cnt_b_m++;
        end else begin
          exp_a.push_back(bus.in_data);
          cnt_a_m++;
        end
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [WIDTH-1:0] d, input logic s);
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.sel      = s;
    for (int t = 0; t < 50 && !ok; t++) begin
      #1;
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_timeout", 64'(ok), 64'(1));
    bus.in_valid = 1'b0;
  endtask
  initial begin
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.sel      = 1'b0;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;
    #3;
    check("rst_a_valid", 64'(bus.a_valid), 64'(0));
    check("rst_a_data", 64'(bus.a_data), 64'(0));
    step(2);
    #2 rst = 1'b0;
    step(1);
    // async reset with one word held in A
    send(32'hCAFE_F00D, 1'b0);
    step(1);
    check("pre_rst_a_valid", 64'(bus.a_valid), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("async_rst_a_valid", 64'(bus.a_valid), 64'(0));
    check("async_rst_a_data", 64'(bus.a_data), 64'(0));
    step(2);
    #2 rst = 1'b0;
    #1 bus.sel = 1'b0;
    #1 check("post_rst_ready_a", 64'(bus.in_ready), 64'(1));
    bus.sel = 1'b1;
    #1 check("post_rst_ready_b", 64'(bus.in_ready), 64'(1));
    step(1);
    // basic steering
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    send(32'hDEAD_BEEF, 1'b0);
    send(32'h1234_5678, 1'b1);
    step(3);
    // fill A, stall, divert to B, then drain A with a pop-while-full cycle
    bus.a_ready = 1'b0;
    send(32'h1, 1'b0);
    send(32'h2, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h3;
    bus.sel      = 1'b0;
    #1 check("fill_in_ready", 64'(bus.in_ready), 64'(0));
    step(2);
    send(32'hB0, 1'b1);
    bus.a_ready = 1'b1;
    send(32'h3, 1'b0);
    step(4);
    // wrap-around on B with a toggling consumer
    for (int i = 0; i < 8; i++) begin
      bus.b_ready = i[0];
      send(32'h10 + 32'(i), 1'b1);
    end
    bus.b_ready = 1'b1;
    step(4);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = 1'($urandom);
      bus.sel      = 1'($urandom);
      bus.in_data  = $urandom;
      bus.a_ready  = ($urandom_range(3) != 0);
      bus.b_ready  = ($urandom_range(3) != 0);
      step(1);
    end
    bus.in_valid = 1'b0;
    bus.a_ready  = 1'b1;
    bus.b_ready  = 1'b1;
    step(6);
    check("drain_a", 64'(exp_a.size()), 64'(0));
    check("drain_b", 64'(exp_b.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
